// File: rtl/multi_cycle_cpu.sv
// Multi-cycle RV32I-subset core with one shared, ready-handshaked memory port.
// Optional jalr support is enabled by defining MULTI_CYCLE_CPU_JALR_EN.
module multi_cycle_cpu #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          REG_COUNT = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic        retire_o,
    output logic        halt_o
);
    localparam int RAW = $clog2(REG_COUNT);
    localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI,
        OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_JALR
    } op_t;

    state_t      state_reg, state_next;
    op_t         op_reg, op_next, dec_op;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] ir_reg, ir_next;
    logic [31:0] a_reg, a_next, b_reg, b_next;
    logic [31:0] imm_reg, imm_next;
    logic [31:0] res_reg, res_next;
    logic [31:0] addr_reg, addr_next;
    logic        retire_reg, retire_next;
    logic        active_reg;
    logic [31:0] rf [REG_COUNT];

    logic        wb_en;
    logic [31:0] wb_data;

    // Instruction fields
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, dec_imm;
    logic        dec_legal, use_rs1, use_rs2, use_rd, reg_ok;

    assign opcode = ir_reg[6:0];
    assign rd     = ir_reg[11:7];
    assign funct3 = ir_reg[14:12];
    assign rs1    = ir_reg[19:15];
    assign rs2    = ir_reg[24:20];
    assign funct7 = ir_reg[31:25];
    assign imm_i  = {{20{ir_reg[31]}}, ir_reg[31:20]};
    assign imm_s  = {{20{ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};
    assign imm_b  = {{19{ir_reg[31]}}, ir_reg[31], ir_reg[7], ir_reg[30:25], ir_reg[11:8], 1'b0};
    assign imm_j  = {{11{ir_reg[31]}}, ir_reg[31], ir_reg[19:12], ir_reg[20], ir_reg[30:21], 1'b0};

    always_comb begin
        dec_legal = 1'b1;
        dec_op    = OP_ADD;
        dec_imm   = imm_i;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        use_rd    = 1'b0;
        case (opcode)
            7'b0110011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: dec_op = OP_ADD;
                    10'b0100000_000: dec_op = OP_SUB;
                    10'b0000000_111: dec_op = OP_AND;
                    10'b0000000_110: dec_op = OP_OR;
                    10'b0000000_010: dec_op = OP_SLT;
                    default:         dec_legal = 1'b0;
                endcase
            end
            7'b0010011: begin
                dec_op    = OP_ADDI;
                dec_legal = (funct3 == 3'b000);
                use_rs1   = 1'b1;
                use_rd    = 1'b1;
            end
            7'b0000011: begin
                dec_op    = OP_LW;
                dec_legal = (funct3 == 3'b010);
                use_rs1   = 1'b1;
                use_rd    = 1'b1;
            end
            7'b0100011: begin
                dec_op    = OP_SW;
                dec_imm   = imm_s;
                dec_legal = (funct3 == 3'b010);
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            7'b1100011: begin
                dec_op    = OP_BEQ;
                dec_imm   = imm_b;
                dec_legal = (funct3 == 3'b000);
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            7'b1101111: begin
                dec_op  = OP_JAL;
                dec_imm = imm_j;
                use_rd  = 1'b1;
            end
`ifdef MULTI_CYCLE_CPU_JALR_EN
            7'b1100111: begin
                dec_op    = OP_JALR;
                dec_legal = (funct3 == 3'b000);
                use_rs1   = 1'b1;
                use_rd    = 1'b1;
            end
`endif
            default: dec_legal = 1'b0;
        endcase
    end

    // Only register fields the instruction actually uses are range-checked
    assign reg_ok = !((use_rs1 && ({1'b0, rs1} >= REG_LIMIT)) ||
                      (use_rs2 && ({1'b0, rs2} >= REG_LIMIT)) ||
                      (use_rd  && ({1'b0, rd}  >= REG_LIMIT)));

    logic [31:0] alu_out, pc_plus4, br_target, jalr_target;

    always_comb begin
        case (op_reg)
            OP_SUB:  alu_out = a_reg - b_reg;
            OP_AND:  alu_out = a_reg & b_reg;
            OP_OR:   alu_out = a_reg | b_reg;
            OP_SLT:  alu_out = {31'b0, $signed(a_reg) < $signed(b_reg)};
            OP_ADD:  alu_out = a_reg + b_reg;
            default: alu_out = a_reg + imm_reg;
        endcase
    end

    assign pc_plus4    = pc_reg + 32'd4;
    assign br_target   = pc_reg + imm_reg;
    assign jalr_target = alu_out & ~32'd1;

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        pc_next     = pc_reg;
        ir_next     = ir_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        imm_next    = imm_reg;
        res_next    = res_reg;
        addr_next   = addr_reg;
        retire_next = 1'b0;
        wb_en       = 1'b0;
        wb_data     = res_reg;
        case (state_reg)
            FETCH: begin
                if (active_reg && mem_ready_i) begin
                    ir_next    = mem_rdata_i;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (!dec_legal || !reg_ok) begin
                    state_next = HALT;
                end else begin
                    a_next     = rf[rs1[RAW-1:0]];
                    b_next     = rf[rs2[RAW-1:0]];
                    imm_next   = dec_imm;
                    op_next    = dec_op;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                case (op_reg)
                    OP_BEQ: begin
                        if (a_reg != b_reg) begin
                            pc_next     = pc_plus4;
                            retire_next = 1'b1;
                            state_next  = FETCH;
                        end else if (br_target[1:0] != 2'b00) begin
                            state_next = HALT;
                        end else begin
                            pc_next     = br_target;
                            retire_next = 1'b1;
                            state_next  = FETCH;
                        end
                    end
                    OP_JAL, OP_JALR: begin
                        if (op_reg == OP_JAL ? (br_target[1:0] != 2'b00)
                                             : (jalr_target[1:0] != 2'b00)) begin
                            state_next = HALT;
                        end else begin
                            wb_en       = 1'b1;
                            wb_data     = pc_plus4;
                            pc_next     = (op_reg == OP_JAL) ? br_target : jalr_target;
                            retire_next = 1'b1;
                            state_next  = FETCH;
                        end
                    end
                    OP_LW, OP_SW: begin
                        if (alu_out[1:0] != 2'b00) begin
                            state_next = HALT;
                        end else begin
                            addr_next  = alu_out;
                            state_next = MEM;
                        end
                    end
                    default: begin
                        res_next   = alu_out;
                        state_next = WB;
                    end
                endcase
            end
            MEM: begin
                if (mem_ready_i) begin
                    if (op_reg == OP_LW) begin
                        res_next   = mem_rdata_i;
                        state_next = WB;
                    end else begin
                        pc_next     = pc_plus4;
                        retire_next = 1'b1;
                        state_next  = FETCH;
                    end
                end
            end
            WB: begin
                wb_en       = 1'b1;
                pc_next     = pc_plus4;
                retire_next = 1'b1;
                state_next  = FETCH;
            end
            default: state_next = HALT;
        endcase
    end

    // active_reg holds off the first request until the first edge after reset release
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg  <= FETCH;
            op_reg     <= OP_ADD;
            pc_reg     <= RESET_PC;
            ir_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            imm_reg    <= '0;
            res_reg    <= '0;
            addr_reg   <= '0;
            retire_reg <= 1'b0;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            pc_reg     <= pc_next;
            ir_reg     <= ir_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            imm_reg    <= imm_next;
            res_reg    <= res_next;
            addr_reg   <= addr_next;
            retire_reg <= retire_next;
            active_reg <= 1'b1;
        end
    end

    // x0 is never written, so it keeps its reset value of zero
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
        end else if (wb_en && (rd != 5'd0)) begin
            rf[rd[RAW-1:0]] <= wb_data;
        end
    end

    assign mem_req_o   = active_reg && ((state_reg == FETCH) || (state_reg == MEM));
    assign mem_we_o    = (state_reg == MEM) && (op_reg == OP_SW);
    assign mem_addr_o  = (state_reg == MEM) ? addr_reg : pc_reg;
    assign mem_wdata_o = b_reg;
    assign retire_o    = retire_reg;
    assign halt_o      = (state_reg == HALT);

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Directed bench for multi_cycle_cpu: word memory model with configurable wait states,
// retire/access logging, and a REG_COUNT=16 instance for the register-range check.
module tb_multi_cycle_cpu;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        mem_req_o, mem_we_o, retire_o, halt_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ready_i = 1'b0;

    logic        req2, we2, retire2, halt2;
    logic [31:0] addr2, wdata2, rdata2;
    logic        ready2;

    always #5 clk = ~clk;

    multi_cycle_cpu #(.RESET_PC(32'h100), .REG_COUNT(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_ready_i(mem_ready_i), .retire_o(retire_o), .halt_o(halt_o)
    );

    multi_cycle_cpu #(.RESET_PC(32'h100), .REG_COUNT(16)) dut16 (
        .clk_i(clk), .rst_i(rst_i), .mem_req_o(req2), .mem_we_o(we2),
        .mem_addr_o(addr2), .mem_wdata_o(wdata2), .mem_rdata_i(rdata2),
        .mem_ready_i(ready2), .retire_o(retire2), .halt_o(halt2)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [31:0] img [256];
    logic [31:0] mem [256];
    int          wait_cycles = 0;
    int          wcnt = 0;
    int          stab_err = 0;
    int          r2_cnt = 0;
    int          req2_after = 0;
    logic        pend_we = 1'b0;
    logic [31:0] pend_addr, pend_data, lat_addr, lat_wdata;
    logic        lat_we;
    int          retire_q[$];
    logic [32:0] acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder and monitor
    always @(negedge clk) begin
        if (!rst_i) begin
            for (int i = 0; i < 256; i++) mem[i] = img[i];
            wcnt = 0;
            pend_we = 1'b0;
            mem_ready_i = 1'b0;
        end else begin
            if (pend_we) begin
                mem[pend_addr[9:2]] = pend_data;
                pend_we = 1'b0;
            end
            if (retire_o) retire_q.push_back(cyc);
            if (retire2) r2_cnt++;
            if (halt2 && req2) req2_after++;
            if (mem_req_o) begin
                if (wcnt == 0) begin
                    lat_addr = mem_addr_o; lat_we = mem_we_o; lat_wdata = mem_wdata_o;
                end else if (lat_addr != mem_addr_o || lat_we != mem_we_o ||
                             (lat_we && lat_wdata != mem_wdata_o)) begin
                    stab_err++;
                end
                if (wcnt == wait_cycles) begin
                    mem_ready_i = 1'b1;
                    mem_rdata_i = mem[mem_addr_o[9:2]];
                    acc_q.push_back({mem_we_o, mem_addr_o});
                    $display("mem %s addr=%h data=%h", mem_we_o ? "wr" : "rd", mem_addr_o,
                             mem_we_o ? mem_wdata_o : mem_rdata_i);
                    if (mem_we_o) begin
                        pend_we = 1'b1; pend_addr = mem_addr_o; pend_data = mem_wdata_o;
                    end
                    wcnt = 0;
                end else begin
                    mem_ready_i = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ready_i = 1'b0;
                wcnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Encoders
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction
    function automatic logic [31:0] addi(int rd, int rs1, int imm); return enc_i(imm, rs1, 0, rd, 7'b0010011); endfunction
    function automatic logic [31:0] lw(int rd, int rs1, int imm);   return enc_i(imm, rs1, 2, rd, 7'b0000011); endfunction
    function automatic logic [31:0] jalr(int rd, int rs1, int imm); return enc_i(imm, rs1, 0, rd, 7'b1100111); endfunction

    localparam logic [31:0] ILL = 32'hFFFF_FFFF;
    int pa, rb, ab, sb, req_cyc;

    task automatic tick; @(negedge clk); #1; endtask

    task automatic clear_img;
        for (int i = 0; i < 256; i++) img[i] = '0;
        pa = 32'h100;
    endtask
    task automatic put(input logic [31:0] w); img[pa >> 2] = w; pa += 4; endtask

    task automatic do_reset(input string tag);
        rst_i = 1'b0;
        repeat (3) tick;
        check({tag, "_rst_req"}, mem_req_o, 0);
        check({tag, "_rst_addr"}, mem_addr_o, 32'h100);
        check({tag, "_rst_misc"}, {mem_we_o, retire_o, halt_o}, 0);
        check({tag, "_rst_wdata"}, mem_wdata_o, 0);
        rb = retire_q.size(); ab = acc_q.size(); sb = stab_err;
        rst_i = 1'b1;
        @(posedge clk); #1;
        check({tag, "_first_req"}, mem_req_o, 1);
        req_cyc = cyc;
    endtask

    task automatic run_until_halt(input string tag, input int limit);
        for (int i = 0; i < limit && !halt_o; i++) tick;
        check({tag, "_halt"}, halt_o, 1);
        repeat (2) tick;
    endtask

    task automatic halted_quiet(input string tag);
        int reqs = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (mem_req_o || retire_o) reqs++;
        end
        check({tag, "_quiet"}, reqs, 0);
    endtask

    initial begin
        rst_i  = 1'b0;
        ready2 = 1'b1;
        rdata2 = enc_r(0, 2, 1, 0, 20);   // add x20,x1,x2

        // Reset and retire
        clear_img;
        put(addi(1, 0, 5)); put(addi(2, 0, -3)); put(enc_r(0, 2, 1, 0, 3));
        put(enc_s(32'h20, 3, 0)); put(ILL);
        do_reset("t1");
        run_until_halt("t1", 200);
        check("t1_x3", mem[8], 32'd2);
        check("t1_retires", retire_q.size() - rb, 4);
        check("t1_fetch0", acc_q[ab][31:0], 32'h100);
        check("t1_fetch1", acc_q[ab+1][31:0], 32'h104);
        check("t1_fetch2", acc_q[ab+2][31:0], 32'h108);
        check("t1_lat_addi", retire_q[rb] - req_cyc, 4);
        check("t1_lat_addi2", retire_q[rb+1] - retire_q[rb], 4);
        check("t1_lat_sw", retire_q[rb+3] - retire_q[rb+2], 4);
        halted_quiet("t1");

        // Memory round-trip with 3 wait states
        wait_cycles = 3;
        clear_img;
        put(lw(1, 0, 32'h40)); put(enc_s(8, 1, 0)); put(lw(4, 0, 8));
        put(enc_s(32'h24, 4, 0)); put(ILL);
        img[16] = 32'hDEAD_BEEF;
        do_reset("t2");
        run_until_halt("t2", 400);
        check("t2_sw", mem[2], 32'hDEAD_BEEF);
        check("t2_x4", mem[9], 32'hDEAD_BEEF);
        check("t2_stable", stab_err - sb, 0);
        check("t2_retires", retire_q.size() - rb, 4);
        check("t2_lat_sw", retire_q[rb+1] - retire_q[rb], 10);
        check("t2_lat_lw", retire_q[rb+2] - retire_q[rb+1], 11);
        wait_cycles = 0;

        // Branch and jump
        clear_img;
        put(addi(1, 0, 7)); put(addi(2, 0, 7)); put(enc_b(64, 0, 1));  // 100,104,108
        put(enc_j(8, 0)); put(ILL); put(enc_j(16, 5));                  // 10C,110,114
        put(ILL); put(enc_s(32'h28, 5, 0)); put(ILL);                   // 118,11C,120
        put(enc_b(-8, 2, 1));                                            // 124
        do_reset("t3");
        run_until_halt("t3", 300);
        check("t3_x5", mem[10], 32'h118);
        check("t3_retires", retire_q.size() - rb, 7);
        check("t3_lat_beq_nt", retire_q[rb+2] - retire_q[rb+1], 3);
        check("t3_lat_jal", retire_q[rb+4] - retire_q[rb+3], 3);
        check("t3_lat_beq_t", retire_q[rb+5] - retire_q[rb+4], 3);
        check("t3_jal_tgt", acc_q[ab+5][31:0], 32'h124);
        check("t3_beq_tgt", acc_q[ab+6][31:0], 32'h11C);
        check("t3_store", acc_q[ab+7], {1'b1, 32'h28});

        // x0 write, slt and the rest of the R-type ops
        clear_img;
        put(addi(7, 0, -1)); put(addi(8, 0, 1)); put(addi(0, 0, 7));
        put(enc_r(0, 8, 7, 2, 6)); put(enc_r(0, 7, 8, 2, 10)); put(enc_r(32, 7, 8, 0, 11));
        put(enc_r(0, 8, 7, 7, 12)); put(enc_r(0, 8, 7, 6, 13)); put(enc_r(0, 7, 7, 0, 14));
        put(enc_s(32'h30, 0, 0)); put(enc_s(32'h34, 6, 0)); put(enc_s(32'h38, 10, 0));
        put(enc_s(32'h3C, 11, 0)); put(enc_s(32'h40, 12, 0)); put(enc_s(32'h44, 13, 0));
        put(enc_s(32'h48, 14, 0)); put(ILL);
        for (int i = 12; i <= 18; i++) img[i] = 32'hA5A5_A5A5;
        do_reset("t4");
        run_until_halt("t4", 400);
        check("t4_x0", mem[12], 32'd0);
        check("t4_slt", mem[13], 32'd1);
        check("t4_slt_rev", mem[14], 32'd0);
        check("t4_sub", mem[15], 32'd2);
        check("t4_and", mem[16], 32'd1);
        check("t4_or", mem[17], 32'hFFFF_FFFF);
        check("t4_add_wrap", mem[18], 32'hFFFF_FFFE);
        check("t4_retires", retire_q.size() - rb, 16);

        // Illegal word
        clear_img;
        put(ILL);
        do_reset("t5a");
        run_until_halt("t5a", 50);
        check("t5a_retires", retire_q.size() - rb, 0);
        check("t5a_accesses", acc_q.size() - ab, 1);
        halted_quiet("t5a");

        // Misaligned load address
        clear_img;
        put(lw(2, 0, 6));
        do_reset("t5b");
        run_until_halt("t5b", 50);
        check("t5b_retires", retire_q.size() - rb, 0);
        check("t5b_accesses", acc_q.size() - ab, 1);
        halted_quiet("t5b");

        // Misaligned branch target
        clear_img;
        put(addi(1, 0, 1)); put(enc_b(6, 0, 0));
        do_reset("t5c");
        run_until_halt("t5c", 50);
        check("t5c_retires", retire_q.size() - rb, 1);
        check("t5c_accesses", acc_q.size() - ab, 2);

        // jalr: legal only when configured in
        clear_img;
        put(jalr(5, 0, 32'h10D)); put(ILL); put(ILL); put(enc_s(32'h50, 5, 0)); put(ILL);
        do_reset("t5d");
        run_until_halt("t5d", 100);
`ifdef MULTI_CYCLE_CPU_JALR_EN
        check("t5d_retires", retire_q.size() - rb, 2);
        check("t5d_link", mem[20], 32'h104);
`else
        check("t5d_retires", retire_q.size() - rb, 0);
        check("t5d_link", mem[20], 32'h0);
`endif

        // REG_COUNT=16 instance fetches add x20 on every access
        check("t5e_halt16", halt2, 1);
        check("t5e_retire16", r2_cnt, 0);
        check("t5e_req16", req2_after, 0);

        // Reset asserted during a fetch wait state
        wait_cycles = 3;
        clear_img;
        put(addi(1, 0, 5)); put(addi(2, 0, -3)); put(enc_r(0, 2, 1, 0, 3));
        put(enc_s(32'h20, 3, 0)); put(ILL);
        do_reset("t6");
        for (int i = 0; i < 200 && retire_q.size() < rb + 2; i++) tick;
        check("t6_progress", retire_q.size() - rb, 2);
        @(posedge clk); #2;
        check("t6_req_before", mem_req_o, 1);
        check("t6_addr_before", mem_addr_o, 32'h108);
        rst_i = 1'b0;
        #1;
        check("t6_req_drop", mem_req_o, 0);
        do_reset("t6r");
        run_until_halt("t6r", 400);
        check("t6_refetch", acc_q[ab][31:0], 32'h100);
        check("t6_x3", mem[8], 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/multi_cycle_cpu.md
# multi_cycle_cpu

Multi-cycle RV32I-subset core, the successor to the single-cycle CPU. It executes each instruction over several states of one FSM. A single shared memory port with a ready handshake carries both instruction fetch and data access, so it works with any memory latency. The core contains its own PC, instruction register, register file and ALU, and sits directly on the system memory bus.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- REG_COUNT, 32, number of architectural registers; legal values 16 or 32. With 16, any rs1/rs2/rd address ≥ 16 is illegal.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- mem_req_o  out  1  memory request valid.
- mem_we_o  out  1  1 = store, 0 = read; valid when mem_req_o = 1.
- mem_addr_o  out  32  byte address, always word-aligned.
- mem_wdata_o  out  32  store data.
- mem_rdata_i  in  32  read data; valid in the cycle mem_ready_i = 1.
- mem_ready_i  in  1  access completes in this cycle.
- retire_o  out  1  one-cycle pulse when an instruction commits.
- halt_o  out  1  core stopped on an illegal instruction or a misaligned target.

## Operation
- Supported instructions: add, sub, and, or, slt, addi, lw, sw, beq, jal. Also jalr when it is configured in (see Configuration).
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Drives mem_req_o = 1, mem_we_o = 0, mem_addr_o = PC.
  - On mem_ready_i, captures mem_rdata_i into IR and moves to DECODE.
- DECODE:
  - Reads rs1 and rs2 into A/B registers and builds the sign-extended immediate.
  - An unsupported opcode/funct, or an out-of-range register, goes to HALT.
- EXEC:
  - R-type/addi: computes the ALU result, then goes to WB.
  - lw/sw: computes rs1 + imm, then goes to MEM.
  - beq: if equal, PC ← PC + imm, else PC ← PC + 4; retires; goes to FETCH.
  - jal: rd ← PC + 4, PC ← PC + imm; retires; goes to FETCH.
- MEM:
  - Holds the request (address, and data for a store) until mem_ready_i.
  - lw goes to WB. sw retires and goes to FETCH.
- WB: writes rd; PC ← PC + 4; retires; goes to FETCH.
- A misaligned data address or branch/jump target (addr[1:0] ≠ 0) goes to HALT. Architectural state is not updated.
- Register x0:
  - Always reads 0.
  - Writes to it are discarded, but retire_o still pulses.
- Arithmetic:
  - 32-bit, wrap-around; no overflow trap.
  - slt is a signed compare.
- HALT is terminal: mem_req_o = 0 and halt_o = 1 until reset.

## Timing
- Reset values:
  - PC = RESET_PC, state = FETCH.
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = RESET_PC, mem_wdata_o = 0.
  - retire_o = 0, halt_o = 0.
  - All registers = 0.
- First mem_req_o = 1 appears in the first cycle after rst_i deasserts.
- Handshake:
  - While mem_req_o = 1, mem_addr_o, mem_we_o and mem_wdata_o are stable.
  - The access completes in the cycle mem_ready_i = 1 is sampled high.
  - mem_req_o drops in the next cycle.
  - mem_ready_i is ignored when mem_req_o = 0.
- Latency with zero wait states (ready high in the first request cycle), measured from the FETCH request cycle to the retire_o pulse:
  - R-type, addi, lw: 4 / 5 cycles.
  - R-type, addi: 4 cycles (FETCH, DECODE, EXEC, WB).
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, jal: 3 cycles.
- Each wait state adds one cycle.
- retire_o is asserted in the same cycle the PC and rd updates become visible, i.e. the cycle after the commit edge.
- Reset asserted mid-access: the FSM, and mem_req_o, go to their reset values immediately (asynchronously). Any in-flight store is abandoned, and the memory side must tolerate this.

## Configuration
- MULTI_CYCLE_CPU_JALR_EN:
  - Defined: jalr (opcode 1100111, funct3 000) is supported. In EXEC, rd ← PC + 4 and PC ← (rs1 + imm) & ~1; a misaligned result halts.
  - Undefined: jalr decodes as illegal and goes to HALT.

## Test plan
- Reset and retire:
  - Stimulus: RESET_PC = 32'h100, zero-wait memory, program `addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2`.
  - Required: x3 = 2, three retire_o pulses, fetch addresses 0x100/0x104/0x108.
- Memory round-trip with wait states:
  - Stimulus: mem_ready_i delayed 3 cycles on every access; program `sw x1,8(x0)` then `lw x4,8(x0)` with x1 = 32'hDEAD_BEEF.
  - Required: x4 = 32'hDEAD_BEEF; request signals stable through every wait cycle.
- Branch and jump:
  - Stimulus: beq with x1 == x2, imm = −8; jal x5, +16.
  - Required: the branch goes to PC − 8 and takes 3 cycles; x5 = old PC + 4.
- x0 write and slt:
  - Stimulus: `addi x0,x0,7`; `slt x6,x7,x8` with x7 = −1, x8 = 1.
  - Required: x0 reads 0; x6 = 1.
- Illegal instruction and misalignment:
  - Stimulus: word 32'hFFFF_FFFF; separately `lw` from address 0x6.
  - Required: halt_o = 1 with no retire pulse and mem_req_o = 0 thereafter. With REG_COUNT = 16, `add x20,...` also halts.
- Reset mid-fetch:
  - Stimulus: assert rst_i low during a FETCH wait state.
  - Required: mem_req_o drops within the same cycle; after release, fetch restarts at RESET_PC.
